// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM request arbiter.
package sram_arb_pkg;

  localparam int unsigned AW_DEF      = 20;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned ERR_RDATA   = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin pick with a lock override for the last-granted port.
module sram_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_hold_i,
  input  logic       lock_port_i,
  output logic       valid_o,
  output logic       pick_o
);

  always_comb begin
    valid_o = |req_i;
    pick_o  = 1'b0;
    if (lock_hold_i && req_i[lock_port_i]) begin
      pick_o = lock_port_i;
    end else if (&req_i) begin
      pick_o = ~last_i;
    end else begin
      pick_o = req_i[1];
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates two requesters onto one SRAM controller port: latch, issue, wait
// for ack (with timeout), then return a one-cycle ack to the granted port.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_write,
  input  logic [2:0]    m0_size,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_write,
  input  logic [2:0]    m1_size,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          ahbsram_req,
  output logic          ahbsram_write,
  output logic [2:0]    ahbsram_size,
  output logic [AW-1:0] ahbsram_addr,
  output logic [DW-1:0] ahbsram_wdata,
  input  logic          sramahb_ack,
  input  logic [DW-1:0] sramahb_rdata,
  input  logic          BUSY,
  output logic          grant_id,
  output logic          arb_busy
);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                lock_q, lock_d;
  logic                lock_hold_q, lock_hold_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic [1:0][DW-1:0]  rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                pick_valid, pick_id;

  sram_rr_pick u_pick (
    .req_i       ({m1_req, m0_req}),
    .last_i      (last_q),
    .lock_hold_i (lock_hold_q),
    .lock_port_i (gnt_q),
    .valid_o     (pick_valid),
    .pick_o      (pick_id)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      lock_hold_q <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      lock_hold_q <= lock_hold_d;
      write_q     <= write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    lock_d      = lock_q;
    lock_hold_d = lock_hold_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = 2'b00;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ahbsram_req = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Lock priority only lasts for this first idle cycle.
        lock_hold_d = 1'b0;
        if (pick_valid) begin
          gnt_d   = pick_id;
          lock_d  = pick_id ? m1_lock  : m0_lock;
          write_d = pick_id ? m1_write : m0_write;
          size_d  = pick_id ? m1_size  : m0_size;
          addr_d  = pick_id ? m1_addr  : m0_addr;
          wdata_d = pick_id ? m1_wdata : m0_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (!BUSY) begin
          ahbsram_req = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sramahb_ack) begin
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = 1'b0;
          rdata_d[gnt_q] = sramahb_rdata;
          state_d        = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = DW'(ERR_RDATA);
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d      = gnt_q;
        lock_hold_d = lock_q && !err_q[gnt_q];
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign m0_ack        = ack_q[0];
  assign m1_ack        = ack_q[1];
  assign m0_err        = err_q[0];
  assign m1_err        = err_q[1];
  assign m0_rdata      = rdata_q[0];
  assign m1_rdata      = rdata_q[1];
  assign ahbsram_write = write_q;
  assign ahbsram_size  = size_q;
  assign ahbsram_addr  = addr_q;
  assign ahbsram_wdata = wdata_q;
  assign grant_id      = gnt_q;
  assign arb_busy      = busy_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a per-cycle vector table plus
// hand-written sequences for write, BUSY, lock, timeout and reset cases.
module tb_sram_req_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          m0_req, m0_lock, m0_write;
  logic [2:0]    m0_size;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_lock, m1_write;
  logic [2:0]    m1_size;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ahbsram_req, ahbsram_write;
  logic [2:0]    ahbsram_size;
  logic [AW-1:0] ahbsram_addr;
  logic [DW-1:0] ahbsram_wdata;
  logic          sramahb_ack;
  logic [DW-1:0] sramahb_rdata;
  logic          BUSY;
  logic          grant_id, arb_busy;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  sram_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write), .m0_size(m0_size),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write), .m1_size(m1_size),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write), .ahbsram_size(ahbsram_size),
    .ahbsram_addr(ahbsram_addr), .ahbsram_wdata(ahbsram_wdata),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY),
    .grant_id(grant_id), .arb_busy(arb_busy)
  );

  typedef struct {
    logic [1:0]  req;       // {m1_req, m0_req}
    logic        ack;
    logic [31:0] rdata;
    logic        exp_areq;
    logic [1:0]  exp_ack;   // {m1_ack, m0_ack}
    logic        exp_gid;
    logic        exp_busy;
    logic [19:0] exp_addr;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 20'h000, 32'h0,        32'h0};
    tbl[1] = '{2'b11, 1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b1, 20'h100, 32'h0,        32'h0};
    tbl[2] = '{2'b11, 1'b1, 32'h12345678, 1'b0, 2'b00, 1'b0, 1'b1, 20'h100, 32'h0,        32'h0};
    tbl[3] = '{2'b11, 1'b0, 32'h0,        1'b0, 2'b01, 1'b0, 1'b1, 20'h100, 32'h12345678, 32'h0};
    tbl[4] = '{2'b10, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 20'h100, 32'h12345678, 32'h0};
    tbl[5] = '{2'b10, 1'b0, 32'h0,        1'b1, 2'b00, 1'b1, 1'b1, 20'h200, 32'h12345678, 32'h0};
    tbl[6] = '{2'b10, 1'b1, 32'h9ABCDEF0, 1'b0, 2'b00, 1'b1, 1'b1, 20'h200, 32'h12345678, 32'h0};
    tbl[7] = '{2'b10, 1'b0, 32'h0,        1'b0, 2'b10, 1'b1, 1'b1, 20'h200, 32'h12345678, 32'h9ABCDEF0};
    tbl[8] = '{2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b1, 1'b0, 20'h200, 32'h12345678, 32'h9ABCDEF0};

    HRESET = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0; m0_write = 1'b0; m0_size = 3'd2;
    m0_addr = 20'h100; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_write = 1'b0; m1_size = 3'd2;
    m1_addr = 20'h200; m1_wdata = 32'h0;
    sramahb_ack = 1'b0; sramahb_rdata = 32'h0; BUSY = 1'b0;

    // Reset values
    nxt(); nxt();
    chk1("rst m0_ack", m0_ack, 1'b0);
    chk1("rst m0_err", m0_err, 1'b0);
    chk1("rst areq", ahbsram_req, 1'b0);
    chk1("rst grant_id", grant_id, 1'b0);
    chk1("rst arb_busy", arb_busy, 1'b0);
    chk32("rst addr", 32'(ahbsram_addr), 32'h0);
    chk32("rst m0_rdata", m0_rdata, 32'h0);
    HRESET = 1'b0;

    // Simultaneous reads out of reset: m0 first, then m1
    for (int i = 0; i < 9; i++) begin
      nxt();
      m0_req = tbl[i].req[0];
      m1_req = tbl[i].req[1];
      sramahb_ack = tbl[i].ack;
      sramahb_rdata = tbl[i].rdata;
      #1;
      chk1($sformatf("T%0d areq", i), ahbsram_req, tbl[i].exp_areq);
      chk32($sformatf("T%0d acks", i), 32'({m1_ack, m0_ack}), 32'(tbl[i].exp_ack));
      chk1($sformatf("T%0d grant_id", i), grant_id, tbl[i].exp_gid);
      chk1($sformatf("T%0d arb_busy", i), arb_busy, tbl[i].exp_busy);
      chk32($sformatf("T%0d addr", i), 32'(ahbsram_addr), 32'(tbl[i].exp_addr));
      chk32($sformatf("T%0d m0_rdata", i), m0_rdata, tbl[i].exp_rd0);
      chk32($sformatf("T%0d m1_rdata", i), m1_rdata, tbl[i].exp_rd1);
    end

    // A: single write, ack two cycles after issue; inputs changed after grant
    nxt();
    m0_req = 1'b1; m0_write = 1'b1; m0_size = 3'd2;
    m0_addr = 20'h00010; m0_wdata = 32'hA5A5A5A5;
    #1;
    chk1("A idle areq", ahbsram_req, 1'b0);
    nxt();
    m0_addr = 20'h3FFFF; m0_wdata = 32'h0; m0_write = 1'b0;
    #1;
    chk1("A areq", ahbsram_req, 1'b1);
    chk32("A addr", 32'(ahbsram_addr), 32'h00010);
    chk32("A wdata", ahbsram_wdata, 32'hA5A5A5A5);
    chk1("A write", ahbsram_write, 1'b1);
    chk32("A size", 32'(ahbsram_size), 32'd2);
    chk1("A grant_id", grant_id, 1'b0);
    nxt(); #1;
    chk1("A areq one cycle", ahbsram_req, 1'b0);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'hDEAD0001;
    #1;
    chk1("A early ack", m0_ack, 1'b0);
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b0;
    #1;
    chk1("A m0_ack", m0_ack, 1'b1);
    chk1("A m0_err", m0_err, 1'b0);
    chk1("A m1_ack", m1_ack, 1'b0);
    chk32("A m0_rdata", m0_rdata, 32'hDEAD0001);
    chk32("A m1_rdata held", m1_rdata, 32'h9ABCDEF0);
    chk32("A addr in resp", 32'(ahbsram_addr), 32'h00010);
    nxt(); #1;
    chk1("A ack pulse", m0_ack, 1'b0);

    // B: BUSY held for 5 cycles in ISSUE
    nxt();
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 20'h0ABCD; BUSY = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk1($sformatf("B busy areq %0d", i), ahbsram_req, 1'b0);
      chk32($sformatf("B busy addr %0d", i), 32'(ahbsram_addr), 32'h0ABCD);
    end
    nxt();
    BUSY = 1'b0;
    #1;
    chk1("B areq", ahbsram_req, 1'b1);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'h00C0FFEE;
    #1;
    chk1("B areq once", ahbsram_req, 1'b0);
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b0;
    #1;
    chk1("B m0_ack", m0_ack, 1'b1);
    chk32("B m0_rdata", m0_rdata, 32'h00C0FFEE);
    nxt(); #1;

    // C: m1 keeps lock for 3 back-to-back reads while m0 waits
    nxt();
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 20'h00777;
    #1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      m0_req = 1'b1; m0_addr = 20'h00888;
      #1;
      chk1($sformatf("C%0d grant_id", i), grant_id, 1'b1);
      chk1($sformatf("C%0d areq", i), ahbsram_req, 1'b1);
      nxt();
      sramahb_ack = 1'b1; sramahb_rdata = 32'(32'h1000 + i);
      #1;
      nxt();
      sramahb_ack = 1'b0;
      #1;
      chk1($sformatf("C%0d m1_ack", i), m1_ack, 1'b1);
      chk1($sformatf("C%0d m0_ack", i), m0_ack, 1'b0);
      chk32($sformatf("C%0d m1_rdata", i), m1_rdata, 32'(32'h1000 + i));
      if (i == 2) begin
        m1_req = 1'b0; m1_lock = 1'b0;
      end
      nxt(); #1;
    end
    nxt(); #1;
    chk1("C m0 grant_id", grant_id, 1'b0);
    chk32("C m0 addr", 32'(ahbsram_addr), 32'h00888);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'h2000;
    #1;
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b0;
    #1;
    chk1("C m0_ack", m0_ack, 1'b1);
    chk1("C m1_ack", m1_ack, 1'b0);
    nxt(); #1;

    // D: controller never acks; timeout then stray ack
    nxt();
    m0_req = 1'b1; m0_addr = 20'h00055;
    #1;
    nxt(); #1;
    chk1("D areq", ahbsram_req, 1'b1);
    for (int i = 0; i < 17; i++) begin
      nxt(); #1;
      chk1($sformatf("D wait %0d", i), m0_ack, 1'b0);
    end
    nxt();
    m0_req = 1'b0;
    #1;
    chk1("D m0_ack", m0_ack, 1'b1);
    chk1("D m0_err", m0_err, 1'b1);
    chk32("D m0_rdata", m0_rdata, 32'h0);
    chk1("D m1_ack", m1_ack, 1'b0);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'hFFFFFFFF;
    #1;
    chk1("D idle busy", arb_busy, 1'b0);
    nxt();
    sramahb_ack = 1'b0;
    #1;
    chk1("D stray m0_ack", m0_ack, 1'b0);
    chk1("D stray m1_ack", m1_ack, 1'b0);
    chk32("D stray m0_rdata", m0_rdata, 32'h0);
    chk1("D err held", m0_err, 1'b1);
    chk1("D stray busy", arb_busy, 1'b0);

    // E: ack arrives in the same cycle the counter hits TIMEOUT
    nxt();
    m0_req = 1'b1;
    #1;
    nxt(); #1;
    for (int i = 0; i < 16; i++) begin
      nxt(); #1;
    end
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'h5A5A0000;
    #1;
    chk1("E before ack", m0_ack, 1'b0);
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b0;
    #1;
    chk1("E m0_ack", m0_ack, 1'b1);
    chk1("E m0_err", m0_err, 1'b0);
    chk32("E m0_rdata", m0_rdata, 32'h5A5A0000);
    nxt(); #1;

    // F: reset during WAIT_ACK, late ack ignored, then a normal request
    nxt();
    m1_req = 1'b1; m1_addr = 20'h00999;
    #1;
    nxt(); #1;
    chk1("F areq", ahbsram_req, 1'b1);
    chk1("F grant_id", grant_id, 1'b1);
    nxt(); #1;
    nxt();
    HRESET = 1'b1;
    #1;
    nxt();
    HRESET = 1'b0; m1_req = 1'b0;
    #1;
    chk1("F rst m1_ack", m1_ack, 1'b0);
    chk1("F rst m0_ack", m0_ack, 1'b0);
    chk1("F rst m1_err", m1_err, 1'b0);
    chk1("F rst busy", arb_busy, 1'b0);
    chk1("F rst grant_id", grant_id, 1'b0);
    chk1("F rst areq", ahbsram_req, 1'b0);
    chk32("F rst addr", 32'(ahbsram_addr), 32'h0);
    chk32("F rst wdata", ahbsram_wdata, 32'h0);
    chk32("F rst m0_rdata", m0_rdata, 32'h0);
    chk32("F rst m1_rdata", m1_rdata, 32'h0);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'hFFFF0000;
    #1;
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b1; m0_addr = 20'h00444;
    #1;
    chk1("F late m1_ack", m1_ack, 1'b0);
    chk1("F late m0_ack", m0_ack, 1'b0);
    nxt(); #1;
    chk1("F new areq", ahbsram_req, 1'b1);
    chk1("F new grant_id", grant_id, 1'b0);
    chk32("F new addr", 32'(ahbsram_addr), 32'h00444);
    nxt();
    sramahb_ack = 1'b1; sramahb_rdata = 32'h0BADF00D;
    #1;
    nxt();
    sramahb_ack = 1'b0; m0_req = 1'b0;
    #1;
    chk1("F new m0_ack", m0_ack, 1'b1);
    chk1("F new m0_err", m0_err, 1'b0);
    chk32("F new m0_rdata", m0_rdata, 32'h0BADF00D);
    nxt(); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Params: AW, 20, address width; DW, 32, data width; TIMEOUT, 255, max cycles waited for sramahb_ack (1..255).
REQ-002 Ports: HCLK in 1, single clock, all logic on rising edge.
REQ-003 Ports: HRESET in 1, reset, synchronous, active-high.
REQ-004 Ports, one per requester n=0,1: mn_req in 1 (level); mn_lock in 1; mn_write in 1; mn_size in 3; mn_addr in AW; mn_wdata in DW.
REQ-005 Ports, one per requester n=0,1: mn_ack out 1 (one-cycle pulse); mn_err out 1; mn_rdata out DW.
REQ-006 Ports, downstream SRAM controller side, outputs: ahbsram_req 1; ahbsram_write 1; ahbsram_size 3; ahbsram_addr AW; ahbsram_wdata DW.
REQ-007 Ports, downstream SRAM controller side, inputs: sramahb_ack 1; sramahb_rdata DW; BUSY 1.
REQ-008 Ports, status outputs: grant_id 1, port that owns the current or last transaction; arb_busy 1, high in any state other than IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK and RESP, one-hot or binary encoded.
REQ-010 IDLE: if any mn_req is high, latch the winner's write/size/addr/wdata into registers, set grant_id, go to ISSUE; otherwise stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: if both requesters are high, grant the port not granted last.
REQ-012 Lock exception: if the last-granted port completed without error, held mn_lock high, and asserts mn_req in the first IDLE cycle, it SHALL win regardless of round-robin.
REQ-013 ISSUE: while BUSY=1, hold in ISSUE with ahbsram_req=0; when BUSY=0, drive ahbsram_req=1 for exactly one cycle and go to WAIT_ACK.
REQ-014 The downstream fields SHALL come from the latched registers and SHALL stay stable from ISSUE through RESP.
REQ-015 WAIT_ACK: an 8-bit counter starts at 0 and increments each cycle.
REQ-016 WAIT_ACK, sramahb_ack=1: capture sramahb_rdata into mn_rdata of the granted port, go to RESP.
REQ-017 WAIT_ACK timeout: if the counter reaches TIMEOUT with no ack, go to RESP with the error flag set and mn_rdata=0.
REQ-018 If sramahb_ack and the timeout occur in the same cycle, the ack SHALL win.
REQ-019 RESP: pulse mn_ack=1 for the granted port only, for one cycle; mn_err equals the error flag in that same cycle; update round-robin pointer; go to IDLE.
REQ-020 Requester rule: mn_req SHALL be dropped on the edge that ends its mn_ack cycle unless a new transaction is wanted; a held mn_req is treated as a new request.
REQ-021 Latency without BUSY or lock: req sampled at cycle t; ahbsram_req at t+1; ack from controller at t+1+k; mn_ack at t+2+k.
REQ-022 A sramahb_ack seen outside WAIT_ACK SHALL be ignored, and no requester ack is produced.
REQ-023 Changes to mn_* fields after grant SHALL have no effect on the transaction in flight.
REQ-024 The non-granted port's mn_ack, mn_err and mn_rdata SHALL remain unchanged.

Reset
REQ-025 On HRESET=1 at a clock edge: state=IDLE; all mn_ack, mn_err=0; mn_rdata=0; ahbsram_req=0; all downstream field registers=0.
REQ-026 On HRESET=1 at a clock edge: counter=0; grant_id=0; round-robin pointer set so port 0 wins the first tie; lock memory cleared; arb_busy=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it without producing mn_ack; a late sramahb_ack after reset is ignored per REQ-022.

Structure
REQ-028 The shared package sram_arb_pkg SHALL hold the state enum, default AW/DW, TIMEOUT and the error-read-data constant (0).
REQ-029 One sub-module, sram_rr_pick (2-way round-robin pick plus lock override, combinational), is natural; everything else stays in the top.

Verification
REQ-030 m0 write only, addr 0x00010, wdata 0xA5A5A5A5, controller acks 2 cycles after ahbsram_req -> one-cycle ahbsram_req with those fields; m0_ack 4 cycles after m0_req, m0_err=0.
REQ-031 m0 and m1 read at the same time, out of reset -> m0 served first, then m1; grant_id goes 0 then 1; each mn_rdata equals its sramahb_rdata (e.g. 0x12345678, 0x9ABCDEF0).
REQ-032 m1 held with lock=1 for 3 back-to-back reads while m0 requests continuously -> m1 served 3 times, then m0 next.
REQ-033 BUSY held high for 5 cycles during ISSUE -> ahbsram_req stays 0 for those 5 cycles, then pulses once; fields stable throughout.
REQ-034 Controller never acks, TIMEOUT=16 -> m0_ack with m0_err=1 and m0_rdata=0 on the cycle after the counter reaches 16; a stray sramahb_ack afterwards produces no ack.
REQ-035 HRESET asserted during WAIT_ACK -> no mn_ack; all outputs at their reset values the next cycle; the next request after release is served normally.
